// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a registered one-hot grant and a
// per-grant hold limit that forces a release after MAX_HOLD cycles.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic       forced_release
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [1:0]      ptr_r, ptr_s;
    logic [1:0]      owner_r, owner_s;
    logic [CW-1:0]   hold_cnt_r, hold_cnt_s;
    logic [3:0]      grant_s;
    logic            grant_valid_s;
    logic            forced_release_s;
    logic [1:0]      winner_s;

    // First requester at or after ptr, wrapping modulo 4.
    function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Next-state and next-output computation.
    always_comb begin
        state_s          = state_r;
        ptr_s            = ptr_r;
        owner_s          = owner_r;
        hold_cnt_s       = hold_cnt_r;
        grant_s          = grant;
        grant_valid_s    = grant_valid;
        forced_release_s = 1'b0;
        winner_s         = pick_winner(req, ptr_r);
        case (state_r)
            IDLE: begin
                if (req != 4'b0000) begin
                    owner_s       = winner_s;
                    grant_s       = 4'b0001 << winner_s;
                    grant_valid_s = 1'b1;
                    hold_cnt_s    = CW'(1);
                    state_s       = GRANT;
                end else begin
                    grant_s       = 4'b0000;
                    grant_valid_s = 1'b0;
                end
            end
            GRANT: begin
                // A still-requesting owner at the limit is a forced release.
                if (!req[owner_r] || (hold_cnt_r == HOLD_LIMIT)) begin
                    grant_s          = 4'b0000;
                    grant_valid_s    = 1'b0;
                    ptr_s            = owner_r + 2'd1;
                    state_s          = IDLE;
                    forced_release_s = req[owner_r];
                end else begin
                    hold_cnt_s = hold_cnt_r + CW'(1);
                end
            end
            default: begin
                state_s       = IDLE;
                grant_s       = 4'b0000;
                grant_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears grant without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            ptr_r          <= 2'd0;
            owner_r        <= 2'd0;
            hold_cnt_r     <= '0;
            grant          <= 4'b0000;
            grant_valid    <= 1'b0;
            forced_release <= 1'b0;
        end else begin
            state_r        <= state_s;
            ptr_r          <= ptr_s;
            owner_r        <= owner_s;
            hold_cnt_r     <= hold_cnt_s;
            grant          <= grant_s;
            grant_valid    <= grant_valid_s;
            forced_release <= forced_release_s;
        end
    end

endmodule
